// File: rtl/uart_rx_if.sv
// Receive-side UART link bundle: serial line in, received byte and status pulses out.
interface uart_rx_if;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  modport master (output rxd, input rx_data, rx_valid, frame_err, busy);
  modport slave  (input rxd, output rx_data, rx_valid, frame_err, busy);
endinterface

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver with 16x oversampling, two-flop line sync, start-bit glitch rejection
// and framing-error detection followed by a wait-for-idle break state.
module uart_rx_deserializer #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.slave bus
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [3:0] SAMP_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] SAMP_LAST = 4'(OVERSAMPLE - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic             r_sync1;
  logic             r_sync2;
  logic [2:0]       r_state;
  logic [DIV_W-1:0] r_div_cnt;
  logic [3:0]       r_samp_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic [7:0]       r_rx_data;
  logic             r_rx_valid;
  logic             r_frame_err;

  logic w_rxs;
  logic w_tick;
  logic w_samp_mid;
  logic w_samp_last;

  assign w_rxs       = r_sync2;
  assign w_tick      = (r_div_cnt == DIV_LAST);
  assign w_samp_mid  = w_tick && (r_samp_cnt == SAMP_MID);
  assign w_samp_last = w_tick && (r_samp_cnt == SAMP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_state     <= S_IDLE;
      r_div_cnt   <= '0;
      r_samp_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync1     <= bus.rxd;
      r_sync2     <= r_sync1;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;

      // Divider parks at zero in IDLE so the first tick lands DIV clocks after the start edge.
      if (r_state == S_IDLE || w_tick) begin
        r_div_cnt <= '0;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end

      if (w_tick) begin
        r_samp_cnt <= r_samp_cnt + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_samp_cnt <= '0;
          r_bit_cnt  <= '0;
          if (!w_rxs) begin
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_samp_mid) begin
            if (w_rxs) begin
              r_state <= S_IDLE;
            end else begin
              r_samp_cnt <= '0;
              r_state    <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_samp_last) begin
            r_shift <= {w_rxs, r_shift[7:1]};
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (w_samp_last) begin
            if (w_rxs) begin
              r_rx_data  <= r_shift;
              r_rx_valid <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          // A held-low line must return high before another start edge is honoured.
          if (w_rxs) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer; frames are generated from bit lists and
// received bytes are compared against the list of bytes that should have arrived.
module tb_uart_rx_deserializer;
  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD     = 1_562_500;
  localparam int DIV      = CLK_FREQ / (BAUD * 16);
  localparam int BIT      = DIV * 16;
  localparam int P_NOM    = BIT * 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  uart_rx_if u_if ();

  uart_rx_deserializer #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (u_if)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  longint     cyc = 0;
  logic [7:0] got_q[$];
  longint     got_cyc[$];
  int         fe_cnt = 0;
  int         busy_rise = 0;
  int         overlap = 0;
  logic       busy_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (u_if.rx_valid) begin
      got_q.push_back(u_if.rx_data);
      got_cyc.push_back(cyc);
    end
    if (u_if.frame_err) fe_cnt <= fe_cnt + 1;
    if (u_if.rx_valid && u_if.frame_err) overlap <= overlap + 1;
    if (u_if.busy && !busy_d) busy_rise <= busy_rise + 1;
    busy_d <= u_if.busy;
  end

  // p is the bit period in hundredths of a clock so fractional baud errors can be driven.
  task automatic send_frame(input logic [7:0] d, input int p, input logic stop_v, output longint t_fall);
    logic [9:0] bits;
    bits   = {stop_v, d, 1'b0};
    t_fall = cyc;
    for (int i = 0; i < 10; i++) begin
      u_if.rxd = bits[i];
      repeat (((i + 1) * p) / 100 - (i * p) / 100) @(negedge clk);
    end
  endtask

  task automatic line_hold(input logic v, input int n);
    u_if.rxd = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 40; i++) line_hold(1'($urandom_range(0, 1)), 1);
    vectors++;
    if (u_if.rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data: got %h expected 00", u_if.rx_data); end
    vectors++;
    if (u_if.rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid: got %b expected 0", u_if.rx_valid); end
    vectors++;
    if (u_if.frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err: got %b expected 0", u_if.frame_err); end
    vectors++;
    if (u_if.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", u_if.busy); end
    line_hold(1'b1, 4);
    rst_n = 1'b1;
    line_hold(1'b1, 20);
    vectors++;
    if (u_if.busy !== 1'b0 || got_q.size() != 0 || fe_cnt != 0) begin
      miscompares++;
      $display("FAIL reset_quiet: busy=%b pulses=%0d fe=%0d expected 0/0/0", u_if.busy, got_q.size(), fe_cnt);
    end
    $display("reset: done");
  endtask

  task automatic test_single();
    int n0, f0;
    longint tf, lat;
    logic [7:0] obs;
    n0 = got_q.size();
    f0 = fe_cnt;
    send_frame(8'hA5, P_NOM, 1'b1, tf);
    line_hold(1'b1, BIT);
    obs = (got_q.size() > n0) ? got_q[n0] : 8'hxx;
    lat = (got_q.size() > n0) ? got_cyc[n0] - tf : -1;
    vectors++;
    if (got_q.size() != n0 + 1) begin miscompares++; $display("FAIL single_count: got %0d expected 1", got_q.size() - n0); end
    vectors++;
    if (obs !== 8'hA5) begin miscompares++; $display("FAIL single_data: got %h expected a5", obs); end
    vectors++;
    if (lat < (BIT * 19) / 2 - 3 || lat > (BIT * 19) / 2 + 9) begin
      miscompares++;
      $display("FAIL single_latency: got %0d clk expected about %0d", lat, (BIT * 19) / 2 + 2);
    end
    vectors++;
    if (fe_cnt != f0) begin miscompares++; $display("FAIL single_frame_err: got %0d expected 0", fe_cnt - f0); end
    vectors++;
    if (u_if.busy !== 1'b0) begin miscompares++; $display("FAIL single_busy: got %b expected 0", u_if.busy); end
    $display("single: sent a5 received %h latency %0d", obs, lat);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    logic [7:0] obs;
    int n0, f0;
    longint tf;
    exp_q = '{8'h00, 8'hFF, 8'h41};
    for (int i = 0; i < 4; i++) exp_q.push_back(8'($urandom));
    n0 = got_q.size();
    f0 = fe_cnt;
    foreach (exp_q[i]) send_frame(exp_q[i], P_NOM, 1'b1, tf);
    line_hold(1'b1, 2 * BIT);
    vectors++;
    if (got_q.size() != n0 + exp_q.size()) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d expected %0d", got_q.size() - n0, exp_q.size());
    end
    foreach (exp_q[i]) begin
      obs = (got_q.size() > n0 + i) ? got_q[n0 + i] : 8'hxx;
      vectors++;
      if (obs !== exp_q[i]) begin miscompares++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, obs, exp_q[i]); end
      $display("b2b: byte %0d sent %h received %h", i, exp_q[i], obs);
    end
    vectors++;
    if (fe_cnt != f0 || overlap != 0) begin
      miscompares++;
      $display("FAIL b2b_errors: frame_err=%0d overlap=%0d expected 0/0", fe_cnt - f0, overlap);
    end
  endtask

  task automatic test_random();
    logic [7:0] d, obs;
    int n0, f0, p, gap;
    longint tf;
    for (int k = 0; k < 8; k++) begin
      d   = 8'($urandom);
      p   = $urandom_range(P_NOM * 98 / 100, P_NOM * 102 / 100);
      gap = $urandom_range(0, BIT);
      n0  = got_q.size();
      f0  = fe_cnt;
      send_frame(d, p, 1'b1, tf);
      line_hold(1'b1, gap + 2);
      obs = (got_q.size() == n0 + 1) ? got_q[n0] : 8'hxx;
      vectors++;
      if (obs !== d || fe_cnt != f0) begin
        miscompares++;
        $display("FAIL random_frame[%0d]: got %h (pulses %0d, fe %0d) expected %h", k, obs, got_q.size() - n0, fe_cnt - f0, d);
      end
      $display("random: sent %h period %0d/100 gap %0d received %h", d, p, gap, obs);
    end
  endtask

  task automatic test_glitch();
    logic [7:0] prev;
    int n0, f0, b0;
    prev = u_if.rx_data;
    n0 = got_q.size();
    f0 = fe_cnt;
    b0 = busy_rise;
    line_hold(1'b0, (BIT / 2) - 8);
    line_hold(1'b1, 2 * BIT);
    vectors++;
    if (busy_rise != b0 + 1) begin miscompares++; $display("FAIL glitch_busy_rise: got %0d expected 1", busy_rise - b0); end
    vectors++;
    if (got_q.size() != n0 || fe_cnt != f0) begin
      miscompares++;
      $display("FAIL glitch_pulses: valid=%0d fe=%0d expected 0/0", got_q.size() - n0, fe_cnt - f0);
    end
    vectors++;
    if (u_if.rx_data !== prev || u_if.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_state: rx_data=%h busy=%b expected %h/0", u_if.rx_data, u_if.busy, prev);
    end
    $display("glitch: low %0d clk, busy rises %0d, pulses %0d", (BIT / 2) - 8, busy_rise - b0, got_q.size() - n0);
  endtask

  task automatic test_frame_err();
    logic [7:0] prev, obs;
    int n0, f0;
    longint tf;
    prev = u_if.rx_data;
    n0 = got_q.size();
    f0 = fe_cnt;
    send_frame(8'h3C, P_NOM, 1'b0, tf);
    line_hold(1'b0, 3 * BIT);
    vectors++;
    if (fe_cnt != f0 + 1) begin miscompares++; $display("FAIL ferr_count: got %0d expected 1", fe_cnt - f0); end
    vectors++;
    if (got_q.size() != n0 || u_if.rx_data !== prev) begin
      miscompares++;
      $display("FAIL ferr_data: rx_data=%h valid=%0d expected %h/0", u_if.rx_data, got_q.size() - n0, prev);
    end
    vectors++;
    if (u_if.busy !== 1'b1) begin miscompares++; $display("FAIL ferr_break_busy: got %b expected 1", u_if.busy); end
    line_hold(1'b1, BIT);
    vectors++;
    if (u_if.busy !== 1'b0) begin miscompares++; $display("FAIL ferr_idle_busy: got %b expected 0", u_if.busy); end
    send_frame(8'h55, P_NOM, 1'b1, tf);
    line_hold(1'b1, BIT);
    obs = (got_q.size() == n0 + 1) ? got_q[n0] : 8'hxx;
    vectors++;
    if (obs !== 8'h55 || fe_cnt != f0 + 1) begin
      miscompares++;
      $display("FAIL ferr_recover: got %h fe=%0d expected 55/1", obs, fe_cnt - f0);
    end
    $display("frame_err: 3c with low stop -> fe %0d, then received %h", fe_cnt - f0, obs);
  endtask

  task automatic test_baud_tol();
    int plist[2];
    logic [7:0] obs;
    int n0, f0;
    longint tf;
    plist = '{P_NOM * 975 / 1000, P_NOM * 1025 / 1000};
    foreach (plist[i]) begin
      n0 = got_q.size();
      f0 = fe_cnt;
      send_frame(8'h96, plist[i], 1'b1, tf);
      line_hold(1'b1, 2 * BIT);
      obs = (got_q.size() == n0 + 1) ? got_q[n0] : 8'hxx;
      vectors++;
      if (obs !== 8'h96 || fe_cnt != f0) begin
        miscompares++;
        $display("FAIL baud_tol[%0d]: got %h fe=%0d expected 96/0", plist[i], obs, fe_cnt - f0);
      end
      $display("baud_tol: period %0d/100 received %h", plist[i], obs);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] bits;
    logic [7:0] obs;
    int n0, f0;
    longint tf;
    bits = {1'b1, 8'h81, 1'b0};
    n0 = got_q.size();
    f0 = fe_cnt;
    for (int i = 0; i < 5; i++) line_hold(bits[i], BIT);
    line_hold(bits[5], BIT / 2);
    rst_n = 1'b0;
    line_hold(bits[5], 2);
    vectors++;
    if (u_if.rx_data !== 8'h00 || u_if.rx_valid !== 1'b0 || u_if.frame_err !== 1'b0 || u_if.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_outputs: data=%h valid=%b fe=%b busy=%b expected 00/0/0/0",
               u_if.rx_data, u_if.rx_valid, u_if.frame_err, u_if.busy);
    end
    line_hold(bits[5], BIT / 2 - 2);
    for (int i = 6; i < 10; i++) line_hold(bits[i], BIT);
    rst_n = 1'b1;
    line_hold(1'b1, 2 * BIT);
    vectors++;
    if (got_q.size() != n0 || fe_cnt != f0) begin
      miscompares++;
      $display("FAIL midrst_dropped: valid=%0d fe=%0d expected 0/0", got_q.size() - n0, fe_cnt - f0);
    end
    send_frame(8'h7E, P_NOM, 1'b1, tf);
    line_hold(1'b1, BIT);
    obs = (got_q.size() == n0 + 1) ? got_q[n0] : 8'hxx;
    vectors++;
    if (obs !== 8'h7E || fe_cnt != f0) begin
      miscompares++;
      $display("FAIL midrst_next: got %h fe=%0d expected 7e/0", obs, fe_cnt - f0);
    end
    $display("reset_mid: 81 dropped, next received %h", obs);
  endtask

  initial begin
    u_if.rxd = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_glitch();
    test_frame_err();
    test_baud_tol();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
